// File: rtl/spi_txn_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI master.
// One transaction at a time: launch, wait for completion or timeout, acknowledge.
module spi_txn_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            reqWr,
  input  logic [DATA_WIDTH-1:0] reqData0,
  input  logic [DATA_WIDTH-1:0] reqData1,
  output logic [1:0]            ack,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic [1:0]            grant,
  output logic                  mstNewTXN,
  output logic                  mstWrEn,
  output logic [DATA_WIDTH-1:0] mstDataIn,
  input  logic                  mstDone,
  input  logic [DATA_WIDTH-1:0] mstRdData
);

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_q, last_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [1:0]            ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  newtxn_q, newtxn_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  pick1;
  logic                  timeout;

  // Requester 1 wins alone, or on contention when requester 0 was served last.
  assign pick1   = req[1] & (~req[0] | ~last_q);
  assign timeout = (cnt_q == CNT_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      cnt_q     <= 16'd0;
      ack_q     <= 2'b00;
      err_q     <= 1'b0;
      newtxn_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      rd_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      newtxn_q  <= newtxn_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (|req) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (mstDone || timeout) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered: each *_d is the value visible in the next state.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ack_d     = 2'b00;
    err_d     = 1'b0;
    newtxn_d  = 1'b0;
    wr_en_d   = wr_en_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          wr_en_d = pick1 ? reqWr[1] : reqWr[0];
          data_d  = pick1 ? reqData1 : reqData0;
        end
      end
      S_LAUNCH: begin
        newtxn_d = 1'b1;
        cnt_d    = 16'd0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // Completion takes priority over a timeout landing in the same cycle.
        if (mstDone) begin
          ack_d = grant_q;
          if (!wr_en_q) rd_data_d = mstRdData;
        end else if (timeout) begin
          ack_d = grant_q;
          err_d = 1'b1;
        end
      end
      S_DONE: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
      end
      default: ;
    endcase
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdData    = rd_data_q;
  assign grant     = grant_q;
  assign mstNewTXN = newtxn_q;
  assign mstWrEn   = wr_en_q;
  assign mstDataIn = data_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: directed corner cases plus randomized
// rounds checked against a transaction-level round-robin/timeout model.
module tb_spi_txn_arbiter;
  localparam int W = 8;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [1:0]   reqWr;
  logic [W-1:0] reqData0;
  logic [W-1:0] reqData1;
  logic [1:0]   ack;
  logic         err;
  logic [W-1:0] rdData;
  logic [1:0]   grant;
  logic         mstNewTXN;
  logic         mstWrEn;
  logic [W-1:0] mstDataIn;
  logic         mstDone;
  logic [W-1:0] mstRdData;

  spi_txn_arbiter #(.DATA_WIDTH(W), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .req(req), .reqWr(reqWr),
    .reqData0(reqData0), .reqData1(reqData1),
    .ack(ack), .err(err), .rdData(rdData), .grant(grant),
    .mstNewTXN(mstNewTXN), .mstWrEn(mstWrEn), .mstDataIn(mstDataIn),
    .mstDone(mstDone), .mstRdData(mstRdData)
  );

  always #5 clk = ~clk;

  // Reference model: pending requests, last-served requester, last read result.
  logic [1:0]   pend;
  logic         pend_wr[2];
  logic [W-1:0] pend_data[2];
  int           last;
  logic [W-1:0] exp_rd;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [1:0] p);
    if (p == 2'b11) return 1 - last;
    return p[1] ? 1 : 0;
  endfunction

  // One full transaction starting from IDLE. done_at >= T means the master never answers.
  task automatic run_round(input logic [1:0] new_req, input logic [1:0] wr_bits,
                           input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input int done_at, input logic [W-1:0] rd_val, input bit drop);
    int         win;
    bit         timed_out;
    int         end_j;
    logic [1:0] g;
    for (int i = 0; i < 2; i++) begin
      if (new_req[i] && !pend[i]) begin
        pend[i]      = 1'b1;
        pend_wr[i]   = wr_bits[i];
        pend_data[i] = (i == 1) ? d1 : d0;
      end
    end
    win       = pick(pend);
    g         = (win == 1) ? 2'b10 : 2'b01;
    timed_out = (done_at >= T);
    end_j     = timed_out ? T - 1 : done_at;

    next_cycle();
    req       = pend;
    reqWr     = {pend_wr[1], pend_wr[0]};
    reqData0  = pend_data[0];
    reqData1  = pend_data[1];
    mstDone   = 1'($urandom_range(0, 1));
    mstRdData = W'($urandom);
    @(negedge clk);
    check("idle_grant", 32'(grant), 32'(0));
    check("idle_ack", 32'(ack), 32'(0));

    next_cycle();
    mstDone = 1'($urandom_range(0, 1));
    if (drop) req[win] = 1'b0;
    @(negedge clk);
    check("launch_grant", 32'(grant), 32'(g));
    check("launch_newtxn", 32'(mstNewTXN), 32'(0));
    check("launch_ack", 32'(ack), 32'(0));

    for (int j = 0; j <= end_j; j++) begin
      next_cycle();
      mstDone   = (j == done_at);
      mstRdData = (j == done_at) ? rd_val : W'($urandom);
      @(negedge clk);
      check("wait_newtxn", 32'(mstNewTXN), 32'(j == 0));
      if (j == 0) begin
        check("mst_data", 32'(mstDataIn), 32'(pend_data[win]));
        check("mst_wr", 32'(mstWrEn), 32'(pend_wr[win]));
      end
      check("wait_ack", 32'(ack), 32'(0));
      check("wait_grant", 32'(grant), 32'(g));
    end

    next_cycle();
    mstDone   = 1'($urandom_range(0, 1));
    mstRdData = W'($urandom);
    if (!timed_out && !pend_wr[win]) exp_rd = rd_val;
    @(negedge clk);
    check("ack", 32'(ack), 32'(g));
    check("err", 32'(err), 32'(timed_out));
    check("rd_data", 32'(rdData), 32'(exp_rd));
    check("done_grant", 32'(grant), 32'(g));
    check("done_newtxn", 32'(mstNewTXN), 32'(0));

    pend[win] = 1'b0;
    last      = win;
  endtask

  task automatic idle_done(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      req       = 2'b00;
      mstDone   = 1'b1;
      mstRdData = W'($urandom);
      @(negedge clk);
      check("spur_ack", 32'(ack), 32'(0));
      check("spur_grant", 32'(grant), 32'(0));
      check("spur_rd", 32'(rdData), 32'(exp_rd));
    end
  endtask

  task automatic reset_mid_wait();
    next_cycle();
    req      = 2'b11;
    reqWr    = 2'b01;
    reqData0 = 8'h11;
    reqData1 = 8'h22;
    mstDone  = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_newtxn", 32'(mstNewTXN), 32'(0));
    check("rst_wr", 32'(mstWrEn), 32'(0));
    check("rst_data", 32'(mstDataIn), 32'(0));
    check("rst_rd", 32'(rdData), 32'(0));
    next_cycle();
    req  = 2'b00;
    rst  = 1'b1;
    pend = 2'b00;
    last = 1;
    exp_rd = '0;
    @(negedge clk);
    check("post_rst_ack", 32'(ack), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] nr;
    rst       = 1'b0;
    req       = 2'b00;
    reqWr     = 2'b00;
    reqData0  = '0;
    reqData1  = '0;
    mstDone   = 1'b0;
    mstRdData = '0;
    pend      = 2'b00;
    pend_wr   = '{1'b0, 1'b0};
    pend_data = '{'0, '0};
    last      = 1;
    exp_rd    = '0;
    #12;
    check("reset_grant", 32'(grant), 32'(0));
    check("reset_ack", 32'(ack), 32'(0));
    check("reset_err", 32'(err), 32'(0));
    check("reset_newtxn", 32'(mstNewTXN), 32'(0));
    check("reset_wr", 32'(mstWrEn), 32'(0));
    check("reset_data", 32'(mstDataIn), 32'(0));
    check("reset_rd", 32'(rdData), 32'(0));
    next_cycle();
    rst = 1'b1;

    idle_done(3);
    run_round(2'b01, 2'b01, 8'hA5, 8'h00, 3, 8'h77, 1'b0);     // single write
    run_round(2'b10, 2'b00, 8'h00, 8'h99, 1, 8'h3C, 1'b0);     // read
    run_round(2'b11, 2'b11, 8'h01, 8'h02, 0, 8'h00, 1'b0);     // contention: 01
    run_round(2'b01, 2'b11, 8'h03, 8'h02, 2, 8'h00, 1'b0);     // contention: 10
    run_round(2'b10, 2'b11, 8'h03, 8'h04, 4, 8'h00, 1'b0);     // contention: 01
    run_round(2'b00, 2'b00, 8'h00, 8'h00, 2, 8'hE1, 1'b1);     // drains 10, req dropped
    run_round(2'b01, 2'b00, 8'h00, 8'h00, T, 8'hDE, 1'b0);     // read timeout
    run_round(2'b10, 2'b00, 8'h00, 8'h00, T - 1, 8'h5A, 1'b0); // done on final cycle
    idle_done(2);
    run_round(2'b01, 2'b01, 8'h6B, 8'h00, 1, 8'h00, 1'b0);     // leaves last served = 0
    reset_mid_wait();
    run_round(2'b11, 2'b00, 8'h00, 8'h00, 2, 8'hC3, 1'b0);     // must grant 01

    for (int r = 0; r < 60; r++) begin
      nr = 2'($urandom_range(0, 3));
      if ((pend | nr) == 2'b00) nr = 2'b01;
      run_round(nr, 2'($urandom), W'($urandom), W'($urandom),
                $urandom_range(0, T + 1), W'($urandom), ($urandom_range(0, 3) == 0));
    end
    while (pend != 2'b00)
      run_round(2'b00, 2'b00, '0, '0, $urandom_range(0, T - 1), W'($urandom), 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
